// File: rtl/rst_seq_gen.sv
// Lock-qualified, synchronously released active-low core reset with software warm reset.
// Optional macro RST_SEQ_CAUSE_EN builds a registered reset-cause output (tied 00 otherwise).
module rst_seq_gen #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 4,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
  input  logic       sw_rst_req_i,
  output logic       rstn_o,
  output logic       rst_done_o,
  output logic [1:0] state_o,
  output logic [1:0] rst_cause_o
);

  localparam int CNT_MAX = ((LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES) - 1;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] STR_LAST  = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    STRETCH   = 2'b01,
    RUN       = 2'b10
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rstn;
  logic                   r_done;
  logic                   w_lock_s;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked_i};
    end
  end

  // Outputs are assigned alongside the state so they track the state register exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_rstn  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (!w_lock_s) begin
            r_cnt <= '0;
          end else if (r_cnt == FILT_LAST) begin
            r_state <= STRETCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STRETCH: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STR_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_rstn  <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_rstn  <= 1'b0;
            r_done  <= 1'b0;
          end else if (sw_rst_req_i) begin
            r_state <= STRETCH;
            r_cnt   <= '0;
            r_rstn  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
          r_rstn  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rstn_o     = r_rstn;
  assign rst_done_o = r_done;
  assign state_o    = r_state;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] r_cause;

  // Lock loss outranks a simultaneous software request, matching the FSM priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cause <= 2'b00;
    end else if (r_state == RUN) begin
      if (!w_lock_s) begin
        r_cause <= 2'b01;
      end else if (sw_rst_req_i) begin
        r_cause <= 2'b10;
      end
    end
  end

  assign rst_cause_o = r_cause;
`else
  assign rst_cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: vector table for the main sequences, hand sequences for corners.
module tb_rst_seq_gen;

`ifdef RST_SEQ_CAUSE_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       locked_i = 1'b0;
  logic       sw_rst_req_i = 1'b0;
  logic       rstn_o;
  logic       rst_done_o;
  logic [1:0] state_o;
  logic [1:0] rst_cause_o;

  int n_cmp = 0;
  int n_bad = 0;

  rst_seq_gen dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .locked_i     (locked_i),
    .sw_rst_req_i (sw_rst_req_i),
    .rstn_o       (rstn_o),
    .rst_done_o   (rst_done_o),
    .state_o      (state_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       lock;
    logic       sw;
    int         n;
    logic [1:0] e_state;
    logic       e_rstn;
    logic       e_done;
    logic [1:0] e_cause;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic r, logic l, logic s, int n,
                              logic [1:0] st, logic rn, logic dn, logic [1:0] ca);
    vec_t v;
    v.name = nm; v.rst_n = r; v.lock = l; v.sw = s; v.n = n;
    v.e_state = st; v.e_rstn = rn; v.e_done = dn; v.e_cause = ca;
    return v;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [1:0] st, input logic rn,
                       input logic dn, input logic [1:0] ca);
    logic [1:0] eca;
    eca = CE ? ca : 2'b00;
    n_cmp++;
    if (state_o !== st) begin
      n_bad++;
      $display("FAIL %s state_o got %b exp %b", nm, state_o, st);
    end
    n_cmp++;
    if (rstn_o !== rn) begin
      n_bad++;
      $display("FAIL %s rstn_o got %b exp %b", nm, rstn_o, rn);
    end
    n_cmp++;
    if (rst_done_o !== dn) begin
      n_bad++;
      $display("FAIL %s rst_done_o got %b exp %b", nm, rst_done_o, dn);
    end
    n_cmp++;
    if (rst_cause_o !== eca) begin
      n_bad++;
      $display("FAIL %s rst_cause_o got %b exp %b", nm, rst_cause_o, eca);
    end
  endtask

  initial begin
    // Edge counts are from the first edge sampling locked_i high after release.
    tbl.push_back(mk("t1_rst",      0, 0, 0,  2, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk("t1_e5",       1, 1, 0,  5, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk("t1_e6",       1, 1, 0,  1, 2'b01, 0, 0, 2'b00));
    tbl.push_back(mk("t1_e21",      1, 1, 0, 15, 2'b01, 0, 0, 2'b00));
    tbl.push_back(mk("t1_e22",      1, 1, 0,  1, 2'b10, 1, 1, 2'b00));
    tbl.push_back(mk("t1_hold",     1, 1, 0,  3, 2'b10, 1, 1, 2'b00));
    tbl.push_back(mk("t3_req",      1, 1, 1,  1, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk("t3_low15",    1, 1, 0, 15, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk("t3_back",     1, 1, 0,  1, 2'b10, 1, 1, 2'b10));
    tbl.push_back(mk("t3l_req",     1, 1, 1,  1, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk("t3l_held",    1, 1, 1, 14, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk("t3l_e15",     1, 1, 0,  1, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk("t3l_e16",     1, 1, 0,  1, 2'b10, 1, 1, 2'b10));
    tbl.push_back(mk("t2_rst",      0, 1, 0,  2, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk("t2_hi3",      1, 1, 0,  3, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk("t2_glitch",   1, 0, 0,  1, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk("t2_e9",       1, 1, 0,  5, 2'b00, 0, 0, 2'b00));
    tbl.push_back(mk("t2_e10",      1, 1, 0,  1, 2'b01, 0, 0, 2'b00));
    tbl.push_back(mk("t2_e25",      1, 1, 0, 15, 2'b01, 0, 0, 2'b00));
    tbl.push_back(mk("t2_e26",      1, 1, 0,  1, 2'b10, 1, 1, 2'b00));

    step(1);
    for (int i = 0; i < tbl.size(); i++) begin
      rst_ni       = tbl[i].rst_n;
      locked_i     = tbl[i].lock;
      sw_rst_req_i = tbl[i].sw;
      step(tbl[i].n);
      check(tbl[i].name, tbl[i].e_state, tbl[i].e_rstn, tbl[i].e_done, tbl[i].e_cause);
    end

    // Lock loss at STRETCH cnt=8, then full relock sequence.
    rst_ni = 1'b0; locked_i = 1'b0; sw_rst_req_i = 1'b0;
    step(1);
    rst_ni = 1'b1; locked_i = 1'b1;
    step(14);
    check("t4_cnt8", 2'b01, 0, 0, 2'b00);
    locked_i = 1'b0;
    step(1);
    check("t4_drop_e1", 2'b01, 0, 0, 2'b00);
    step(1);
    check("t4_drop_e2", 2'b01, 0, 0, 2'b00);
    step(1);
    check("t4_wait", 2'b00, 0, 0, 2'b00);
    locked_i = 1'b1;
    step(5);
    check("t4_re_e5", 2'b00, 0, 0, 2'b00);
    step(1);
    check("t4_re_e6", 2'b01, 0, 0, 2'b00);
    step(15);
    check("t4_re_e21", 2'b01, 0, 0, 2'b00);
    step(1);
    check("t4_re_e22", 2'b10, 1, 1, 2'b00);

    // Lock loss and software request seen together in RUN.
    locked_i = 1'b0;
    step(1);
    check("t5_sync1", 2'b10, 1, 1, 2'b00);
    step(1);
    check("t5_sync2", 2'b10, 1, 1, 2'b00);
    sw_rst_req_i = 1'b1;
    step(1);
    check("t5_both", 2'b00, 0, 0, 2'b01);
    sw_rst_req_i = 1'b0;
    step(2);
    check("t5_stay", 2'b00, 0, 0, 2'b01);

    // Asynchronous reset between edges mid-STRETCH, then a full fresh sequence.
    locked_i = 1'b1;
    step(10);
    check("t6_pre", 2'b01, 0, 0, 2'b01);
    #3;
    rst_ni = 1'b0;
    #1;
    check("t6_async", 2'b00, 0, 0, 2'b00);
    step(1);
    rst_ni = 1'b1;
    step(21);
    check("t6_e21", 2'b01, 0, 0, 2'b00);
    step(1);
    check("t6_e22", 2'b10, 1, 1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
